// File: rtl/icache_refill_controller_if.sv
// Bundle of fetch, cache-array, memory-refill, flush and counter signals for the refill controller.
// slave = controller side, master = environment side.
interface icache_refill_controller_if #(
  parameter int NFU                     = 2,
  parameter int NCACHE_ENTRIES          = 256,
  parameter int PHYSICAL_ADDRESS_LENGTH = 56
);
  localparam int PAL  = PHYSICAL_ADDRESS_LENGTH;
  localparam int IDX  = $clog2(NCACHE_ENTRIES);
  localparam int OFF  = $clog2(NFU * 4);
  localparam int TAG  = PAL - IDX - OFF;
  localparam int LINE = 1 + TAG + NFU * 32;

  logic              reqValid;
  logic              reqReady;
  logic [PAL-1:0]    reqAddress;
  logic              respValid;
  logic [NFU*32-1:0] respData;
  logic              respError;
  logic              arrReadEn;
  logic              arrWriteEn;
  logic [IDX-1:0]    arrIndex;
  logic [LINE-1:0]   arrReadLine;
  logic [LINE-1:0]   arrWriteLine;
  logic              memReqValid;
  logic              memReqReady;
  logic [PAL-1:0]    memReqAddress;
  logic              memBeatValid;
  logic [31:0]       memBeatData;
  logic              flushReq;
  logic              flushBusy;
  logic [31:0]       hitCount;
  logic [31:0]       missCount;

  modport slave (
    input  reqValid, reqAddress, arrReadLine, memReqReady, memBeatValid, memBeatData, flushReq,
    output reqReady, respValid, respData, respError, arrReadEn, arrWriteEn, arrIndex,
           arrWriteLine, memReqValid, memReqAddress, flushBusy, hitCount, missCount
  );

  modport master (
    output reqValid, reqAddress, arrReadLine, memReqReady, memBeatValid, memBeatData, flushReq,
    input  reqReady, respValid, respData, respError, arrReadEn, arrWriteEn, arrIndex,
           arrWriteLine, memReqValid, memReqAddress, flushBusy, hitCount, missCount
  );
endinterface

// File: rtl/icache_refill_controller.sv
// Instruction-cache refill controller: lookup, line refill from memory, full-cache flush.
// state   | meaning
// IDLE    | ready for a request; starts a pending flush first
// LOOKUP  | array read data valid, hit/miss decision
// MEMREQ  | line-aligned memory request held until accepted
// REFILL  | collecting NFU beats into the line buffer
// WRITE   | one-cycle array write of the refilled line
// RESPOND | one-cycle response pulse
// FLUSH   | invalidating one index per cycle
module icache_refill_controller #(
  parameter int NFU                     = 2,
  parameter int NCACHE_ENTRIES          = 256,
  parameter int PHYSICAL_ADDRESS_LENGTH = 56
) (
  input logic                       clk,
  input logic                       rstN,
  icache_refill_controller_if.slave bus
);
  localparam int PAL  = PHYSICAL_ADDRESS_LENGTH;
  localparam int IDX  = $clog2(NCACHE_ENTRIES);
  localparam int OFF  = $clog2(NFU * 4);
  localparam int TAG  = PAL - IDX - OFF;
  localparam int LINE = 1 + TAG + NFU * 32;
  localparam int DW   = NFU * 32;
  localparam int BW   = (NFU > 1) ? $clog2(NFU) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, MEMREQ, REFILL, WRITE, RESPOND, FLUSH} state_t;

  state_t             r_state;
  logic [PAL-OFF-1:0] r_line_addr;
  logic [DW-1:0]      r_data;
  logic               r_err;
  logic [BW-1:0]      r_beat;
  logic [IDX-1:0]     r_flush_idx;
  logic               r_flush_pending;
  logic [31:0]        r_hit_cnt;
  logic [31:0]        r_miss_cnt;

  logic w_ready;
  logic w_accept;
  logic w_aligned;
  logic w_hit;

  // A flush request arriving in IDLE wins over a simultaneous fetch request.
  assign w_ready   = (r_state == IDLE) && !r_flush_pending && !bus.flushReq;
  assign w_accept  = bus.reqValid && w_ready && rstN;
  assign w_aligned = (bus.reqAddress[OFF-1:0] == '0);
  assign w_hit     = bus.arrReadLine[LINE-1] &&
                     (bus.arrReadLine[LINE-2 -: TAG] == r_line_addr[PAL-OFF-1 -: TAG]);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state         <= IDLE;
      r_line_addr     <= '0;
      r_data          <= '0;
      r_err           <= 1'b0;
      r_beat          <= '0;
      r_flush_idx     <= '0;
      r_flush_pending <= 1'b0;
      r_hit_cnt       <= '0;
      r_miss_cnt      <= '0;
    end else begin
      if (bus.flushReq && r_state != FLUSH) r_flush_pending <= 1'b1;
      case (r_state)
        IDLE: begin
          if (r_flush_pending || bus.flushReq) begin
            r_state     <= FLUSH;
            r_flush_idx <= '0;
          end else if (w_accept) begin
            r_line_addr <= bus.reqAddress[PAL-1:OFF];
            if (w_aligned) begin
              r_state <= LOOKUP;
              r_err   <= 1'b0;
            end else begin
              r_state <= RESPOND;
              r_err   <= 1'b1;
              r_data  <= '0;
            end
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            r_data    <= bus.arrReadLine[DW-1:0];
            r_hit_cnt <= r_hit_cnt + 32'd1;
            r_state   <= RESPOND;
          end else begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
            r_beat     <= '0;
            r_state    <= MEMREQ;
          end
        end
        MEMREQ: if (bus.memReqReady) r_state <= REFILL;
        REFILL: begin
          if (bus.memBeatValid) begin
            r_data[32*r_beat +: 32] <= bus.memBeatData;
            if (r_beat == BW'(NFU - 1)) begin
              r_beat  <= '0;
              r_state <= WRITE;
            end else begin
              r_beat <= r_beat + BW'(1);
            end
          end
        end
        WRITE:   r_state <= RESPOND;
        RESPOND: r_state <= IDLE;
        FLUSH: begin
          r_flush_idx <= r_flush_idx + IDX'(1);
          if (r_flush_idx == IDX'(NCACHE_ENTRIES - 1)) begin
            r_flush_pending <= 1'b0;
            r_state         <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.arrIndex = '0;
    if (w_accept && w_aligned) bus.arrIndex = bus.reqAddress[OFF+IDX-1:OFF];
    else if (r_state == WRITE) bus.arrIndex = r_line_addr[IDX-1:0];
    else if (r_state == FLUSH) bus.arrIndex = r_flush_idx;
  end

  assign bus.reqReady      = w_ready;
  assign bus.respValid     = (r_state == RESPOND);
  assign bus.respError     = (r_state == RESPOND) && r_err;
  assign bus.respData      = (r_state == RESPOND) ? r_data : '0;
  assign bus.arrReadEn     = w_accept && w_aligned;
  assign bus.arrWriteEn    = (r_state == WRITE) || (r_state == FLUSH);
  assign bus.arrWriteLine  = (r_state == WRITE) ?
                             {1'b1, r_line_addr[PAL-OFF-1 -: TAG], r_data} : '0;
  assign bus.memReqValid   = (r_state == MEMREQ);
  assign bus.memReqAddress = (r_state == MEMREQ) ? {r_line_addr, {OFF{1'b0}}} : '0;
  assign bus.flushBusy     = r_flush_pending;
  assign bus.hitCount      = r_hit_cnt;
  assign bus.missCount     = r_miss_cnt;
endmodule

// File: tb/tb_icache_refill_controller.sv
// Directed bench for icache_refill_controller: hit, miss/refill, misaligned, flush, reset mid-refill.
module tb_icache_refill_controller;
  localparam int NFU  = 2;
  localparam int NENT = 256;
  localparam int PAL  = 56;
  localparam int TAG  = 45;
  localparam int LINE = 110;

  localparam logic [TAG-1:0] TAG_A  = 45'h123;
  localparam logic [TAG-1:0] TAG_B  = 45'h1ABC;
  localparam logic [PAL-1:0] ADDR_A = {TAG_A, 8'd5, 3'd0};
  localparam logic [PAL-1:0] ADDR_B = {TAG_B, 8'd9, 3'd0};
  localparam logic [63:0]    DATA_A = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0]    DATA_B = 64'h22222222_11111111;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  icache_refill_controller_if #(.NFU(NFU), .NCACHE_ENTRIES(NENT), .PHYSICAL_ADDRESS_LENGTH(PAL)) bus ();

  icache_refill_controller #(.NFU(NFU), .NCACHE_ENTRIES(NENT), .PHYSICAL_ADDRESS_LENGTH(PAL)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  // Cache array model: synchronous write, read data valid one cycle after arrReadEn.
  logic [LINE-1:0] mem [NENT];
  logic [LINE-1:0] rd_line;
  logic            clr;
  logic            pre_en;
  logic [7:0]      pre_idx;
  logic [LINE-1:0] pre_line;
  assign bus.arrReadLine = rd_line;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NENT; i++) mem[i] <= '0;
      rd_line <= '0;
    end else if (pre_en) begin
      mem[pre_idx] <= pre_line;
    end else begin
      if (bus.arrWriteEn) mem[bus.arrIndex] <= bus.arrWriteLine;
      if (bus.arrReadEn) rd_line <= mem[bus.arrIndex];
    end
  end

  int resp_seen = 0;
  int wr_seen   = 0;
  int collide   = 0;
  always @(posedge clk) begin
    if (bus.respValid) resp_seen <= resp_seen + 1;
    if (bus.arrWriteEn) wr_seen <= wr_seen + 1;
    if (bus.arrReadEn && bus.arrWriteEn) collide <= collide + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hit_request(input string tag, input logic [PAL-1:0] addr, input logic [7:0] idx,
                             input logic [63:0] data, input int hits);
    @(negedge clk);
    bus.reqValid   = 1'b1;
    bus.reqAddress = addr;
    #1;
    check({tag, "_rd_en"}, bus.arrReadEn, 1'b1);
    check({tag, "_rd_idx"}, bus.arrIndex, idx);
    @(negedge clk);
    bus.reqValid = 1'b0;
    check({tag, "_lookup_no_resp"}, bus.respValid, 1'b0);
    @(negedge clk);
    check({tag, "_resp_valid"}, bus.respValid, 1'b1);
    check({tag, "_resp_data"}, bus.respData, data);
    check({tag, "_resp_err"}, bus.respError, 1'b0);
    check({tag, "_hit_count"}, bus.hitCount, hits);
    @(negedge clk);
    check({tag, "_resp_pulse_end"}, bus.respValid, 1'b0);
    check({tag, "_resp_data_zero"}, bus.respData, 64'd0);
  endtask

  int good;
  int wr0;
  int rs0;

  initial begin
    rstN = 1'b0;
    bus.reqValid = 1'b0;     bus.reqAddress = '0;
    bus.memReqReady = 1'b0;  bus.memBeatValid = 1'b0;  bus.memBeatData = '0;
    bus.flushReq = 1'b0;
    clr = 1'b1; pre_en = 1'b0; pre_idx = '0; pre_line = '0;

    repeat (2) @(negedge clk);
    check("rst_req_ready", bus.reqReady, 1'b1);
    check("rst_resp_valid", bus.respValid, 1'b0);
    check("rst_arr_we", bus.arrWriteEn, 1'b0);
    check("rst_mem_req", bus.memReqValid, 1'b0);
    check("rst_flush_busy", bus.flushBusy, 1'b0);
    check("rst_hit_count", bus.hitCount, 32'd0);
    clr = 1'b0;
    pre_en = 1'b1; pre_idx = 8'd5; pre_line = {1'b1, TAG_A, DATA_A};
    @(negedge clk);
    pre_en = 1'b0;
    rstN = 1'b1;
    @(negedge clk);
    check("ready_after_rst", bus.reqReady, 1'b1);

    hit_request("hitA", ADDR_A, 8'd5, DATA_A, 1);

    // Miss on an invalid line, with a stray beat before the memory request is accepted.
    @(negedge clk);
    bus.reqValid = 1'b1; bus.reqAddress = ADDR_B;
    @(negedge clk);
    bus.reqValid = 1'b0;
    @(negedge clk);
    check("miss_mem_req", bus.memReqValid, 1'b1);
    check("miss_mem_addr", bus.memReqAddress, ADDR_B);
    check("miss_count", bus.missCount, 32'd1);
    bus.memBeatValid = 1'b1; bus.memBeatData = 32'hBAD0BAD0;
    @(negedge clk);
    bus.memBeatValid = 1'b0;
    check("miss_mem_req_held", bus.memReqValid, 1'b1);
    check("miss_mem_addr_held", bus.memReqAddress, ADDR_B);
    bus.memReqReady = 1'b1;
    @(negedge clk);
    bus.memReqReady = 1'b0;
    check("refill_mem_req_drop", bus.memReqValid, 1'b0);
    bus.memBeatValid = 1'b1; bus.memBeatData = 32'h11111111;
    @(negedge clk);
    bus.memBeatValid = 1'b0;
    @(negedge clk);
    bus.memBeatValid = 1'b1; bus.memBeatData = 32'h22222222;
    @(negedge clk);
    bus.memBeatValid = 1'b0;
    check("write_we", bus.arrWriteEn, 1'b1);
    check("write_no_re", bus.arrReadEn, 1'b0);
    check("write_idx", bus.arrIndex, 8'd9);
    check("write_line", bus.arrWriteLine, {1'b1, TAG_B, DATA_B});
    @(negedge clk);
    check("miss_resp_valid", bus.respValid, 1'b1);
    check("miss_resp_data", bus.respData, DATA_B);
    check("miss_resp_err", bus.respError, 1'b0);
    @(negedge clk);
    check("miss_resp_pulse_end", bus.respValid, 1'b0);

    @(negedge clk);
    bus.reqValid = 1'b1; bus.reqAddress = 56'h4;
    #1;
    check("misal_no_rd", bus.arrReadEn, 1'b0);
    @(negedge clk);
    bus.reqValid = 1'b0;
    check("misal_resp_valid", bus.respValid, 1'b1);
    check("misal_resp_err", bus.respError, 1'b1);
    check("misal_resp_data", bus.respData, 64'd0);
    check("misal_hits", bus.hitCount, 32'd1);
    check("misal_misses", bus.missCount, 32'd1);
    @(negedge clk);
    check("misal_back_idle", bus.reqReady, 1'b1);

    hit_request("hitB", ADDR_B, 8'd9, DATA_B, 2);

    // Flush and fetch in the same IDLE cycle: flush wins, a second flushReq mid-flush is ignored.
    @(negedge clk);
    bus.flushReq = 1'b1; bus.reqValid = 1'b1; bus.reqAddress = ADDR_B;
    #1;
    check("flush_prio_ready", bus.reqReady, 1'b0);
    check("flush_prio_no_rd", bus.arrReadEn, 1'b0);
    @(negedge clk);
    bus.flushReq = 1'b0; bus.reqValid = 1'b0;
    good = 0;
    for (int i = 0; i < NENT; i++) begin
      if (bus.arrWriteEn && bus.flushBusy && !bus.arrReadEn &&
          bus.arrIndex == 8'(i) && bus.arrWriteLine == '0) good++;
      bus.flushReq = (i == 100);
      @(negedge clk);
    end
    bus.flushReq = 1'b0;
    check("flush_writes", good, NENT);
    check("flush_done_we", bus.arrWriteEn, 1'b0);
    check("flush_done_busy", bus.flushBusy, 1'b0);
    check("flush_done_ready", bus.reqReady, 1'b1);

    // Post-flush request misses; reset after the first refill beat abandons the refill.
    bus.reqValid = 1'b1; bus.reqAddress = ADDR_B;
    @(negedge clk);
    bus.reqValid = 1'b0;
    @(negedge clk);
    check("post_flush_mem_req", bus.memReqValid, 1'b1);
    check("post_flush_misses", bus.missCount, 32'd2);
    bus.memReqReady = 1'b1;
    @(negedge clk);
    bus.memReqReady = 1'b0;
    bus.memBeatValid = 1'b1; bus.memBeatData = 32'h11111111;
    @(negedge clk);
    bus.memBeatValid = 1'b0;
    wr0 = wr_seen;
    rs0 = resp_seen;
    rstN = 1'b0;
    #1;
    check("rst_mid_hits", bus.hitCount, 32'd0);
    check("rst_mid_misses", bus.missCount, 32'd0);
    check("rst_mid_ready", bus.reqReady, 1'b1);
    check("rst_mid_resp", bus.respValid, 1'b0);
    @(negedge clk);
    bus.memBeatValid = 1'b1; bus.memBeatData = 32'h33333333;
    @(negedge clk);
    rstN = 1'b1;
    #1;
    check("rel_ready", bus.reqReady, 1'b1);
    @(negedge clk);
    bus.memBeatValid = 1'b0;
    repeat (3) @(negedge clk);
    check("abandon_no_write", wr_seen, wr0);
    check("abandon_no_resp", resp_seen, rs0);
    check("abandon_misses", bus.missCount, 32'd0);
    check("abandon_ready", bus.reqReady, 1'b1);
    check("no_rd_wr_collision", collide, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
